sha256_msg_padder: RTL and testbench
====================================

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the message word count.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a message; ignored when busy=1.
REQ-005 SHALL have port msg_words  input  LEN_W  message length in 32-bit words (N), sampled when start is accepted.
REQ-006 SHALL have port in_valid  input  1  upstream data word valid.
REQ-007 SHALL have port in_data  input  32  upstream message word, big-endian.
REQ-008 SHALL have port in_ready  output  1  padder accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data valid toward SHA-256 core.
REQ-010 SHALL have port out_data  output  32  padded block word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 SHALL have port out_blk_end  output  1  out_data is word 15 of a 512-bit block.
REQ-013 SHALL have port out_last  output  1  out_data is the final word of the final block.
REQ-014 SHALL have port busy  output  1  message in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-016 SHALL emit, per message, N data words, then 0x80000000, then zero words, then the 64-bit bit length (N*32), high word then low word, so that the total word count is 16*ceil((N+3)/16).
REQ-017 SHALL place the high length word at block index 14 and the low length word at block index 15 of the final block.
REQ-018 SHALL compute the length zero-extended to 64 bits; the high word SHALL be 0 for LEN_W<=27.
REQ-019 SHALL implement the states IDLE, DATA, PAD80, ZERO, LENHI and LENLO.
REQ-020 Transitions SHALL be:
- IDLE->DATA on start (N>0).
- IDLE->PAD80 on start (N=0).
- DATA->PAD80 when the Nth word is accepted.
- PAD80->ZERO if the pad word's block index is not 13.
- PAD80->LENHI if the pad word's block index is 13.
- ZERO->LENHI after the word at index 13 is emitted.
- LENHI->LENLO.
- LENLO->IDLE when the final word is accepted.
REQ-021 SHALL hold out_data, out_valid, out_blk_end and out_last in registers, stable while out_valid=1 and out_ready=0.
REQ-022 SHALL advance the output register only when out_valid=0 or out_ready=1.
REQ-023 SHALL drive in_ready = (state==DATA) and (out_valid=0 or out_ready=1), with no combinational path from in_valid to in_ready.
REQ-024 SHALL present an accepted input word on out_data on the next cycle (1-cycle latency), supporting one word per cycle throughput.
REQ-025 SHALL track block word index with a 4-bit counter that wraps 15->0; out_blk_end SHALL equal (index==15).
REQ-026 SHALL count accepted input words with a LEN_W-bit counter; N=2^LEN_W-1 SHALL be supported without overflow.
REQ-027 SHALL assert busy from the cycle after start acceptance until done.
REQ-028 SHALL assert done for exactly one cycle, in the cycle after the out_last handshake; busy SHALL fall in that same cycle.
REQ-029 SHALL ignore in_valid outside DATA.
REQ-030 SHALL ignore start while busy=1 or done=1.

Reset
REQ-031 On rst_n=0, SHALL asynchronously enter IDLE with in_ready=0, out_valid=0, out_data=0, out_blk_end=0, out_last=0, busy=0 and done=0, and all counters cleared.
REQ-032 Reset mid-message SHALL discard all partial state; the next start SHALL begin a fresh message at block index 0.

Verification
REQ-033 N=0 -> 16 words: 0x80000000, 14x 0x00000000, 0x00000000 (last); out_last and out_blk_end on word 15; done one cycle later.
REQ-034 N=13, data 1..13 -> one block: words 1..13, 0x80000000 at index 13, 0 at index 14, 0x000001A0 at index 15 with out_last.
REQ-035 N=14 -> two blocks: 0x80000000 at block0 index 14, 0 at block0 index 15 (out_blk_end=1, out_last=0), block1 indices 0-14 zero, 0x000001C0 at index 15 with out_last.
REQ-036 N=40, random out_ready backpressure, random in_valid gaps -> 48 words, three blocks, 0x80000000 at word 40, 0x00000500 last; out_data stable through every stall; no word dropped or duplicated.
REQ-037 start pulsed during busy -> ignored, output stream unchanged; back-to-back messages (start on the done cycle+1) -> second message correct.
REQ-038 rst_n low at N=40 word 20 -> all outputs per REQ-031 immediately; a subsequent N=13 message matches REQ-034 exactly.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: forwards N upstream words, then appends 0x80000000,
// zero fill and the 64-bit bit length so the stream ends on a 512-bit boundary.
module sha256_msg_padder #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_words,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             out_blk_end,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  // Handshake: a word moves on a rising edge where valid and ready are both 1.
  // The producer holds its word and flags stable until that edge; ready never
  // depends on the partner's valid in the same cycle.

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PAD80, S_ZERO, S_LENHI, S_LENLO
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] n_words;
  logic [LEN_W-1:0] word_cnt;
  logic [3:0]       blk_idx;
  logic             adv;
  logic [63:0]      bit_len;

  assign adv      = !out_valid || out_ready;
  assign in_ready = (state == S_DATA) && adv;
  assign bit_len  = 64'(n_words) << 5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      n_words     <= '0;
      word_cnt    <= '0;
      blk_idx     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_blk_end <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid   <= 1'b0;
        out_blk_end <= 1'b0;
        out_last    <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          // done=1 means the previous message just closed; its start slot is dead.
          if (start && !done) begin
            n_words  <= msg_words;
            word_cnt <= '0;
            blk_idx  <= '0;
            busy     <= 1'b1;
            state    <= (msg_words == '0) ? S_PAD80 : S_DATA;
          end
        end
        S_DATA: begin
          if (in_valid && adv) begin
            out_valid   <= 1'b1;
            out_data    <= in_data;
            out_blk_end <= (blk_idx == 4'd15);
            out_last    <= 1'b0;
            blk_idx     <= blk_idx + 4'd1;
            word_cnt    <= word_cnt + LEN_W'(1);
            if (word_cnt == n_words - LEN_W'(1)) state <= S_PAD80;
          end
        end
        S_PAD80: begin
          if (adv) begin
            out_valid   <= 1'b1;
            out_data    <= 32'h8000_0000;
            out_blk_end <= (blk_idx == 4'd15);
            out_last    <= 1'b0;
            blk_idx     <= blk_idx + 4'd1;
            state       <= (blk_idx == 4'd13) ? S_LENHI : S_ZERO;
          end
        end
        S_ZERO: begin
          if (adv) begin
            out_valid   <= 1'b1;
            out_data    <= 32'h0;
            out_blk_end <= (blk_idx == 4'd15);
            out_last    <= 1'b0;
            blk_idx     <= blk_idx + 4'd1;
            if (blk_idx == 4'd13) state <= S_LENHI;
          end
        end
        S_LENHI: begin
          if (adv) begin
            out_valid   <= 1'b1;
            out_data    <= bit_len[63:32];
            out_blk_end <= (blk_idx == 4'd15);
            out_last    <= 1'b0;
            blk_idx     <= blk_idx + 4'd1;
            state       <= S_LENLO;
          end
        end
        S_LENLO: begin
          // First visit loads the low length word; then wait for it to be taken.
          if (!out_last) begin
            if (adv) begin
              out_valid   <= 1'b1;
              out_data    <= bit_len[31:0];
              out_blk_end <= (blk_idx == 4'd15);
              out_last    <= 1'b1;
              blk_idx     <= blk_idx + 4'd1;
            end
          end else if (out_valid && out_ready) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: table of message vectors plus directed corner
// sequences, all words scored against a queue built from the padding rules.
module tb_sha256_msg_padder;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] msg_words;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_ready;
  logic             out_blk_end;
  logic             out_last;
  logic             busy;
  logic             done;

  sha256_msg_padder #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_words(msg_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_blk_end(out_blk_end), .out_last(out_last), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    bit          seq_data;
    int          gap_pct;
    int          bp_pct;
    int          exp_total;
    logic [31:0] exp_last;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;
  logic [33:0] exp_q[$];
  logic [33:0] e;
  logic [33:0] held;
  int          words_seen = 0;
  logic [31:0] last_word = '0;
  bit          expect_done = 1'b0;
  bit          stalled = 1'b0;
  int          bp_pct = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // downstream backpressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) >= bp_pct);
    end
  end

  // scoreboard / stall monitor
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stalled     = 1'b0;
      expect_done = 1'b0;
    end else begin
      check("done_timing", 64'(done), 64'(expect_done));
      expect_done = 1'b0;
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_word", 64'({out_last, out_blk_end, out_data}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word got=%0h want=none t=%0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'({out_last, out_blk_end, out_data}), 64'(e));
        end
        words_seen++;
        if (out_last) begin
          last_word   = out_data;
          expect_done = 1'b1;
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_last, out_blk_end, out_data};
    end
  end

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_blk_end", 64'(out_blk_end), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
  endtask

  // driver: one message, optional abort by reset, optional stray starts
  task automatic run_msg(input int n, input bit seq_data, input int gap_pct, input int bp,
                         input int abort_at, input bit poke_busy, input bit poke_done);
    logic [31:0] msg[$];
    logic [63:0] bits;
    int          tot;
    int          i;
    int          budget;
    bp_pct = bp;
    for (int k = 0; k < n; k++) msg.push_back(seq_data ? 32'(k + 1) : $urandom());
    tot  = 16 * ((n + 3 + 15) / 16);
    bits = 64'(n) * 64'd32;
    for (int p = 0; p < tot; p++) begin
      logic [31:0] w;
      if (p < n) w = msg[p];
      else if (p == n) w = 32'h8000_0000;
      else if (p == tot - 2) w = bits[63:32];
      else if (p == tot - 1) w = bits[31:0];
      else w = 32'h0;
      exp_q.push_back({p == tot - 1, (p % 16) == 15, w});
    end
    words_seen = 0;
    start      = 1'b1;
    msg_words  = LEN_W'(n);
    @(posedge clk); #1;
    start  = 1'b0;
    i      = 0;
    budget = 0;
    while (i < n && budget < 4000) begin
      if (abort_at >= 0 && i == abort_at) break;
      if (poke_busy && budget == 3) begin
        start     = 1'b1;
        msg_words = LEN_W'(5);
      end else start = 1'b0;
      if ($urandom_range(99) < gap_pct) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = msg[i];
      end
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    if (abort_at >= 0) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      return;
    end
    check("feed_count", 64'(i), 64'(n));
    // words offered outside DATA must be ignored
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    budget   = 0;
    while (!done && budget < 4000) begin
      @(posedge clk); #1;
      budget++;
    end
    check("done_seen", 64'(done), 64'(1));
    check("busy_fall", 64'(busy), 64'(0));
    in_valid = 1'b0;
    if (poke_done) begin
      start     = 1'b1;
      msg_words = LEN_W'(3);
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse", 64'(done), 64'(0));
    if (poke_done) check("start_on_done", 64'(busy), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    vecs.push_back('{0,  1'b1, 0,  0,  16, 32'h0000_0000});
    vecs.push_back('{13, 1'b1, 0,  0,  16, 32'h0000_01A0});
    vecs.push_back('{14, 1'b1, 0,  0,  32, 32'h0000_01C0});
    vecs.push_back('{40, 1'b0, 30, 40, 48, 32'h0000_0500});
    vecs.push_back('{1,  1'b0, 20, 20, 16, 32'h0000_0020});
    vecs.push_back('{16, 1'b0, 0,  50, 32, 32'h0000_0200});
    vecs.push_back('{29, 1'b0, 10, 30, 32, 32'h0000_03A0});
    vecs.push_back('{30, 1'b1, 0,  0,  48, 32'h0000_03C0});

    rst_n     = 1'b0;
    start     = 1'b0;
    msg_words = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      run_msg(vecs[v].n, vecs[v].seq_data, vecs[v].gap_pct, vecs[v].bp_pct, -1, 1'b0, 1'b0);
      check("total_words", 64'(words_seen), 64'(vecs[v].exp_total));
      check("last_word", 64'(last_word), 64'(vecs[v].exp_last));
    end

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(0, 50));
      run_msg(n, 1'b0, 25, 35, -1, 1'b0, 1'b0);
      check("rand_total", 64'(words_seen), 64'(16 * ((n + 18) / 16)));
      check("rand_last", 64'(last_word), 64'(n * 32));
    end

    // stray start while busy
    run_msg(20, 1'b0, 10, 20, -1, 1'b1, 1'b0);
    check("busy_poke_total", 64'(words_seen), 64'(32));

    // start on the done cycle is dropped; next message starts right after
    run_msg(5, 1'b0, 0, 0, -1, 1'b0, 1'b1);
    run_msg(3, 1'b0, 0, 30, -1, 1'b0, 1'b0);
    check("b2b_total", 64'(words_seen), 64'(16));
    check("b2b_last", 64'(last_word), 64'(32'h60));

    // reset in the middle of a message, then a clean message
    run_msg(40, 1'b0, 0, 0, 20, 1'b0, 1'b0);
    run_msg(13, 1'b1, 0, 0, -1, 1'b0, 1'b0);
    check("post_rst_total", 64'(words_seen), 64'(16));
    check("post_rst_last", 64'(last_word), 64'(32'h1A0));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
